// File: rtl/rule_serializer_pkg.sv
// Shared constants and state encoding for the rule-ID serializer.
package rule_serializer_pkg;

   localparam int NUM_LANES   = 8;
   localparam int LANE_W      = 16;
   localparam int RULE_AWIDTH = $clog2(NUM_LANES);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_DRAIN = 2'd1,
      ST_TERM  = 2'd2
   } ser_state_e;

endpackage

// File: rtl/rule_serializer_lane_pri_enc.sv
// Lowest-set-bit priority encoder over the held lane mask.
module lane_pri_enc #(
   parameter int NUM_LANES = 8,
   parameter int IDX_W     = 3
) (
   input  logic [NUM_LANES-1:0] mask_i,
   output logic [IDX_W-1:0]     idx_o,
   output logic                 any_o
);

   // Scan from the top so the lowest set bit is the one left standing.
   always_comb begin
      idx_o = '0;
      any_o = 1'b0;
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
         if (mask_i[i]) begin
            idx_o = IDX_W'(i);
            any_o = 1'b1;
         end else begin
            any_o = any_o;
         end
      end
   end

endmodule

// File: rtl/rule_serializer.sv
// Serializes a beat of packed rule-ID lanes into one rule ID per cycle,
// ending every packet with exactly one last word (a zero terminator when needed).
module rule_serializer #(
   parameter int NUM_LANES = rule_serializer_pkg::NUM_LANES,
   parameter int LANE_W    = rule_serializer_pkg::LANE_W
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_LANES*LANE_W-1:0] in_usr_data,
   input  logic                        in_usr_valid,
   input  logic                        in_usr_sop,
   input  logic                        in_usr_eop,
   input  logic [3:0]                  in_usr_empty,
   output logic                        in_usr_ready,
   output logic [LANE_W-1:0]           out_rule_data,
   output logic                        out_rule_valid,
   output logic                        out_rule_last,
   output logic                        out_rule_none,
   input  logic                        out_rule_ready,
   output logic [31:0]                 rule_cnt,
   output logic [31:0]                 pkt_cnt,
   output logic [31:0]                 sop_err_cnt
);

   import rule_serializer_pkg::*;

   localparam int DATA_W = NUM_LANES * LANE_W;

   ser_state_e                 state_q, state_d;
   logic [DATA_W-1:0]          data_q, data_d;
   logic [NUM_LANES-1:0]       mask_q, mask_d;
   logic                       eop_q, eop_d;
   logic                       seen_q, seen_d;
   logic                       open_q, open_d;
   logic [31:0]                rule_cnt_q, rule_cnt_d;
   logic [31:0]                pkt_cnt_q, pkt_cnt_d;
   logic [31:0]                sop_err_q, sop_err_d;

   logic [NUM_LANES-1:0]       in_mask_s;
   logic [NUM_LANES-1:0]       rem_mask_s;
   logic [RULE_AWIDTH-1:0]     pri_idx_s;
   logic                       pri_any_s;
   logic                       last_bit_s;
   logic                       ready_s;
   logic                       accept_s;
   logic                       hs_s;
   logic                       unused_s;

   lane_pri_enc #(
      .NUM_LANES (NUM_LANES),
      .IDX_W     (RULE_AWIDTH)
   ) u_pri (
      .mask_i (mask_q),
      .idx_o  (pri_idx_s),
      .any_o  (pri_any_s)
   );

   // Lane-occupancy mask of the incoming beat.
   always_comb begin
      in_mask_s = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         in_mask_s[i] = |in_usr_data[i*LANE_W +: LANE_W];
      end
   end

   assign rem_mask_s = mask_q & ~(NUM_LANES'(1) << pri_idx_s);
   assign last_bit_s = (rem_mask_s == '0);
   assign unused_s   = ^in_usr_empty ^ pri_any_s;

   // Output word and upstream ready; ready is only offered once the held beat empties.
   always_comb begin
      out_rule_valid = 1'b0;
      out_rule_data  = '0;
      out_rule_last  = 1'b0;
      out_rule_none  = 1'b0;
      ready_s        = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            ready_s = 1'b1;
         end
         ST_DRAIN: begin
            out_rule_valid = 1'b1;
            out_rule_data  = data_q[int'(pri_idx_s)*LANE_W +: LANE_W];
            out_rule_last  = eop_q & last_bit_s;
            ready_s        = out_rule_ready & last_bit_s;
         end
         ST_TERM: begin
            out_rule_valid = 1'b1;
            out_rule_last  = 1'b1;
            out_rule_none  = ~seen_q;
            ready_s        = out_rule_ready;
         end
         default: begin
            ready_s = 1'b0;
         end
      endcase
   end

   assign in_usr_ready = ready_s & ~rst;
   assign accept_s     = in_usr_valid & in_usr_ready;
   assign hs_s         = out_rule_valid & out_rule_ready;

   // Next-state: drain handshake first, then a same-cycle accept reloads without a bubble.
   always_comb begin
      state_d    = state_q;
      data_d     = data_q;
      mask_d     = mask_q;
      eop_d      = eop_q;
      seen_d     = seen_q;
      open_d     = open_q;
      rule_cnt_d = rule_cnt_q;
      pkt_cnt_d  = pkt_cnt_q;
      sop_err_d  = sop_err_q;

      if (hs_s) begin
         if (state_q == ST_DRAIN) begin
            mask_d     = rem_mask_s;
            seen_d     = 1'b1;
            rule_cnt_d = rule_cnt_q + 32'd1;
            state_d    = last_bit_s ? ST_EMPTY : ST_DRAIN;
         end else begin
            state_d = ST_EMPTY;
         end
         pkt_cnt_d = out_rule_last ? pkt_cnt_q + 32'd1 : pkt_cnt_q;
      end else begin
         state_d = state_q;
      end

      if (accept_s) begin
         data_d = in_usr_data;
         mask_d = in_mask_s;
         eop_d  = in_usr_eop;
         if (|in_mask_s) begin
            state_d = ST_DRAIN;
         end else if (in_usr_eop) begin
            state_d = ST_TERM;
         end else begin
            state_d = ST_EMPTY;
         end
         if (in_usr_sop) begin
            seen_d    = 1'b0;
            sop_err_d = open_q ? sop_err_q + 32'd1 : sop_err_q;
         end else begin
            seen_d = seen_d;
         end
         open_d = in_usr_eop ? 1'b0 : (in_usr_sop ? 1'b1 : open_q);
      end else begin
         open_d = open_q;
      end
   end

   // State and counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_EMPTY;
         data_q     <= '0;
         mask_q     <= '0;
         eop_q      <= 1'b0;
         seen_q     <= 1'b0;
         open_q     <= 1'b0;
         rule_cnt_q <= 32'd0;
         pkt_cnt_q  <= 32'd0;
         sop_err_q  <= 32'd0;
      end else begin
         state_q    <= state_d;
         data_q     <= data_d;
         mask_q     <= mask_d;
         eop_q      <= eop_d;
         seen_q     <= seen_d;
         open_q     <= open_d;
         rule_cnt_q <= rule_cnt_d;
         pkt_cnt_q  <= pkt_cnt_d;
         sop_err_q  <= sop_err_d;
      end
   end

   assign rule_cnt    = rule_cnt_q;
   assign pkt_cnt     = pkt_cnt_q;
   assign sop_err_cnt = sop_err_q;

endmodule
